screen_arbiter: RTL and testbench
=================================

Name: screen_arbiter

Overview:
- Shares the single-port screen RAM (8K x 16, Hack 0x4000–0x5FFF) between two requesters: the CPU data port, via the Memory block, and the VGA scanout fetcher.
- VGA has absolute priority, so scanout never stalls.
- CPU writes are posted into a 1-entry write buffer. CPU reads stall through cpu_busy, which feeds the mem_busy path.
- Reads that hit the posted write are forwarded from the buffer.

Parameters:
ADDR_WIDTH, 13, screen RAM word address width
DATA_WIDTH, 16, word width

Ports:
clk  in  1  system clock (PLL output domain)
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held with stable address/load/wdata until accepted
cpu_load  in  1  1 = write, 0 = read
cpu_address  in  ADDR_WIDTH  CPU word address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rdata  out  DATA_WIDTH  CPU read data; valid in the accept cycle of a read
cpu_busy  out  1  CPU must hold its request; low = accepted this cycle
vga_req  in  1  VGA fetch request; may assert any cycle
vga_address  in  ADDR_WIDTH  VGA word address
vga_rdata  out  DATA_WIDTH  VGA fetch data
vga_valid  out  1  vga_rdata valid; exactly 1 cycle after vga_req
ram_address  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_WIDTH  RAM read data, 1-cycle registered latency

Behaviour:
- Reset
  - Synchronous. wbuf invalid; FSM to IDLE.
  - vga_valid=0, ram_we=0, cpu_rdata=0, vga_rdata=0.
  - cpu_busy=0 while reset is asserted.
  - A posted write or in-flight read present when reset asserts is discarded.
- Per-cycle RAM grant, in priority order:
  1. vga_req
  2. wbuf drain, when wbuf is valid
  3. CPU read issue, when in IDLE with a read pending and wbuf empty
  - Only one grant per cycle. ram_we=1 only for a wbuf drain.
- VGA path
  - vga_req in cycle N is always granted in N.
  - vga_valid=1 and vga_rdata=ram_rdata in N+1.
  - Back-to-back VGA requests give back-to-back valids.
- CPU write
  - Accepted (cpu_busy=0) in the request cycle if wbuf is empty, or if wbuf drains in that same cycle. The new write loads wbuf at the clock edge.
  - Otherwise cpu_busy=1 until that condition holds.
  - A write to the address already in wbuf (wbuf not draining) overwrites wbuf data and is accepted.
- CPU read
  - Forwarding: if wbuf is valid and cpu_address == wbuf address, the read is accepted in the same cycle, cpu_busy=0, cpu_rdata=wbuf data (combinational).
  - Otherwise cpu_busy=1. Once wbuf is empty and no VGA request is present, issue the read (IDLE -> RD_WAIT).
  - RD_WAIT lasts one cycle: cpu_rdata=ram_rdata, cpu_busy=0, then back to IDLE.
  - Minimum miss latency is 1 stall cycle.
  - A read never bypasses an older posted write to a different address; the drain always completes first.
- FSM states: IDLE, RD_WAIT. No VGA state, since the VGA path is a 1-cycle valid pipeline register.
- Ordering and consistency
  - A VGA read and a wbuf drain to the same address: VGA is granted first, so it returns the old data; the drain follows.
  - A VGA read never observes a half-written word.
- Starvation
  - None inherent: VGA duty cycle is at most 1 fetch per 16 pixel clocks, so the CPU progresses within ≤ 2 free slots.
  - Continuous vga_req stalls the CPU indefinitely. This is legal.
- cpu_rdata holds its last value outside accept cycles.

Decomposition:
- Shared package: ADDR_WIDTH/DATA_WIDTH defaults and FSM state encodings IDLE/RD_WAIT.
- Sub-module write_post_buffer: valid/address/data register with load, overwrite, drain and address-match compare outputs.
- Arbitration and FSM stay in screen_arbiter.

Test Plan:
1. Reset during a posted write (wbuf holds addr 0x0010) -> after reset: ram_we never asserts for 0x0010, cpu_busy=0, vga_valid=0.
2. CPU write 0x1234 to addr 0x0005, no VGA traffic -> cpu_busy=0 in the request cycle; next cycle ram_we=1, ram_address=0x0005, ram_wdata=0x1234.
3. Write 0xBEEF to 0x0100, then read 0x0100 in the next cycle while VGA holds vga_req high (blocking the drain) -> read accepted immediately, cpu_rdata=0xBEEF.
4. Read 0x0200 (RAM holds 0xA5A5) with wbuf valid at 0x0300 and vga_req asserted for 2 cycles -> VGA valids on both following cycles; drain of 0x0300, then read issue; cpu_busy=1 for 4 cycles; cpu_rdata=0xA5A5 on the accept cycle.
5. Two consecutive CPU writes while vga_req is continuously high -> first accepted, second cpu_busy=1 until vga_req drops; the drain and second accept then happen in the same cycle.
6. vga_req in cycle N at 0x1FFF (top address) with RAM 0x00FF -> vga_valid=1, vga_rdata=0x00FF in N+1, with no CPU interference.

Source files
------------

// File: rtl/screen_arbiter_pkg.sv
// Shared widths and arbiter FSM encoding for the screen RAM arbiter.
package screen_arbiter_pkg;
  localparam int ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/screen_arbiter_write_post_buffer.sv
// One-entry posted-write buffer: load/overwrite beats drain in the same cycle,
// and an address compare drives read forwarding and same-address overwrite.
module write_post_buffer
  import screen_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] compare_address,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  match
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      address <= '0;
      data    <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      address <= load_address;
      data    <= load_data;
    end else if (drain) begin
      valid   <= 1'b0;
    end
  end

  assign match = valid && (address == compare_address);

endmodule

// File: rtl/screen_arbiter.sv
// Single-port screen RAM arbiter: VGA fetch has absolute priority, then the
// posted-write drain, then CPU read misses; CPU reads hitting the posted write are forwarded.
module screen_arbiter
  import screen_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_load,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_busy,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_address,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_valid,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  arb_state_t            state, state_next;
  logic                  wbuf_valid, wbuf_match;
  logic [ADDR_WIDTH-1:0] wbuf_address;
  logic [DATA_WIDTH-1:0] wbuf_data;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, vga_rdata_q;
  logic                  drain, wr_accept, rd_fwd, rd_issue, cpu_idle_read;

  // Drain only in slots VGA leaves free; reset suppresses any pending drain.
  assign drain         = !reset && wbuf_valid && !vga_req;
  assign cpu_idle_read = !reset && (state == IDLE) && cpu_req && !cpu_load;
  assign wr_accept     = !reset && (state == IDLE) && cpu_req && cpu_load &&
                         (!wbuf_valid || drain || wbuf_match);
  assign rd_fwd        = cpu_idle_read && wbuf_match;
  assign rd_issue      = cpu_idle_read && !wbuf_valid && !vga_req;

  write_post_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clk            (clk),
    .reset          (reset),
    .load           (wr_accept),
    .drain          (drain),
    .load_address   (cpu_address),
    .load_data      (cpu_wdata),
    .compare_address(cpu_address),
    .valid          (wbuf_valid),
    .address        (wbuf_address),
    .data           (wbuf_data),
    .match          (wbuf_match)
  );

  always_comb begin
    ram_address = cpu_address;
    if (vga_req) begin
      ram_address = vga_address;
    end else if (wbuf_valid) begin
      ram_address = wbuf_address;
    end
  end

  assign ram_we    = drain;
  assign ram_wdata = wbuf_data;

  always_comb begin
    state_next = state;
    cpu_busy   = 1'b0;
    cpu_rdata  = cpu_rdata_q;
    case (state)
      IDLE: begin
        if (rd_issue) state_next = RD_WAIT;
        if (rd_fwd) cpu_rdata = wbuf_data;
        if (cpu_req && !wr_accept && !rd_fwd) cpu_busy = 1'b1;
      end
      RD_WAIT: begin
        state_next = IDLE;
        cpu_rdata  = ram_rdata;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      state_next = IDLE;
      cpu_busy   = 1'b0;
      cpu_rdata  = cpu_rdata_q;
    end
  end

  assign vga_rdata = vga_valid ? ram_rdata : vga_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      vga_valid   <= 1'b0;
    end else begin
      state       <= state_next;
      cpu_rdata_q <= cpu_rdata;
      vga_rdata_q <= vga_rdata;
      vga_valid   <= vga_req;
    end
  end

endmodule

// File: tb/tb_screen_arbiter.sv
// Directed bench for screen_arbiter: reset sequence by hand, then a per-cycle vector table.
module tb_screen_arbiter;
  import screen_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_load;
  logic [12:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic        vga_req;
  logic [12:0] vga_address;
  logic [15:0] vga_rdata;
  logic        vga_valid;
  logic [12:0] ram_address;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  logic [15:0] mem [0:8191];
  logic        watch = 1'b0;
  logic        bad_drain = 1'b0;
  int          tests = 0;
  int          fails = 0;

  screen_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_load   (cpu_load),
    .cpu_address(cpu_address),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_busy   (cpu_busy),
    .vga_req    (vga_req),
    .vga_address(vga_address),
    .vga_rdata  (vga_rdata),
    .vga_valid  (vga_valid),
    .ram_address(ram_address),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-old-data on a same-cycle write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
    if (watch && ram_we && ram_address == 13'h0010) bad_drain <= 1'b1;
  end

  typedef struct {
    logic        req;
    logic        load;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic        vreq;
    logic [12:0] vaddr;
    logic        e_busy;
    logic        e_we;
    logic        e_vvalid;
    logic        chk_ram;
    logic [12:0] e_raddr;
    logic [15:0] e_wdata;
    logic        chk_rd;
    logic [15:0] e_rd;
    logic        chk_vrd;
    logic [15:0] e_vrd;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic req, input logic load,
                       input logic [12:0] addr, input logic [15:0] wdata,
                       input logic vreq, input logic [12:0] vaddr);
    @(negedge clk);
    reset       = rst;
    cpu_req     = req;
    cpu_load    = load;
    cpu_address = addr;
    cpu_wdata   = wdata;
    vga_req     = vreq;
    vga_address = vaddr;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'hC000 | 16'(i);
    mem[13'h0200] = 16'hA5A5;
    mem[13'h1FFF] = 16'h00FF;

    //          req  load  addr      wdata     vreq  vaddr     busy  we    vv    chkr  raddr     rwdata    chkrd rd        chkv  vrd
    vecs[0]  = '{1'b1,1'b1,13'h0005,16'h1234,1'b0,13'h0000, 1'b0,1'b0,1'b0, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[1]  = '{1'b0,1'b0,13'h0000,16'h0000,1'b0,13'h0000, 1'b0,1'b1,1'b0, 1'b1,13'h0005,16'h1234, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[2]  = '{1'b1,1'b1,13'h0100,16'hBEEF,1'b1,13'h0000, 1'b0,1'b0,1'b0, 1'b1,13'h0000,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[3]  = '{1'b1,1'b0,13'h0100,16'h0000,1'b1,13'h0001, 1'b0,1'b0,1'b1, 1'b1,13'h0001,16'h0000, 1'b1,16'hBEEF, 1'b1,16'hC000};
    vecs[4]  = '{1'b0,1'b0,13'h0000,16'h0000,1'b0,13'h0000, 1'b0,1'b1,1'b1, 1'b1,13'h0100,16'hBEEF, 1'b0,16'h0000, 1'b1,16'hC001};
    vecs[5]  = '{1'b1,1'b1,13'h0300,16'h3333,1'b1,13'h0002, 1'b0,1'b0,1'b0, 1'b1,13'h0002,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[6]  = '{1'b1,1'b0,13'h0200,16'h0000,1'b1,13'h0003, 1'b1,1'b0,1'b1, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b1,16'hC002};
    vecs[7]  = '{1'b1,1'b0,13'h0200,16'h0000,1'b1,13'h0004, 1'b1,1'b0,1'b1, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b1,16'hC003};
    vecs[8]  = '{1'b1,1'b0,13'h0200,16'h0000,1'b0,13'h0000, 1'b1,1'b1,1'b1, 1'b1,13'h0300,16'h3333, 1'b0,16'h0000, 1'b1,16'hC004};
    vecs[9]  = '{1'b1,1'b0,13'h0200,16'h0000,1'b0,13'h0000, 1'b1,1'b0,1'b0, 1'b1,13'h0200,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[10] = '{1'b1,1'b0,13'h0200,16'h0000,1'b0,13'h0000, 1'b0,1'b0,1'b0, 1'b0,13'h0000,16'h0000, 1'b1,16'hA5A5, 1'b0,16'h0000};
    vecs[11] = '{1'b0,1'b0,13'h0000,16'h0000,1'b0,13'h0000, 1'b0,1'b0,1'b0, 1'b0,13'h0000,16'h0000, 1'b1,16'hA5A5, 1'b0,16'h0000};
    vecs[12] = '{1'b1,1'b1,13'h0400,16'h4444,1'b1,13'h0005, 1'b0,1'b0,1'b0, 1'b1,13'h0005,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[13] = '{1'b1,1'b1,13'h0401,16'h4545,1'b1,13'h0006, 1'b1,1'b0,1'b1, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b1,16'h1234};
    vecs[14] = '{1'b1,1'b1,13'h0401,16'h4545,1'b1,13'h0007, 1'b1,1'b0,1'b1, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b1,16'hC006};
    vecs[15] = '{1'b1,1'b1,13'h0401,16'h4545,1'b0,13'h0000, 1'b0,1'b1,1'b1, 1'b1,13'h0400,16'h4444, 1'b0,16'h0000, 1'b1,16'hC007};
    vecs[16] = '{1'b0,1'b0,13'h0000,16'h0000,1'b0,13'h0000, 1'b0,1'b1,1'b0, 1'b1,13'h0401,16'h4545, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[17] = '{1'b0,1'b0,13'h0000,16'h0000,1'b1,13'h1FFF, 1'b0,1'b0,1'b0, 1'b1,13'h1FFF,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[18] = '{1'b0,1'b0,13'h0000,16'h0000,1'b0,13'h0000, 1'b0,1'b0,1'b1, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b1,16'h00FF};
    vecs[19] = '{1'b1,1'b1,13'h0500,16'h0001,1'b1,13'h0008, 1'b0,1'b0,1'b0, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[20] = '{1'b1,1'b1,13'h0500,16'h0002,1'b1,13'h0008, 1'b0,1'b0,1'b1, 1'b0,13'h0000,16'h0000, 1'b0,16'h0000, 1'b1,16'hC008};
    vecs[21] = '{1'b0,1'b0,13'h0000,16'h0000,1'b0,13'h0000, 1'b0,1'b1,1'b1, 1'b1,13'h0500,16'h0002, 1'b0,16'h0000, 1'b1,16'hC008};
    vecs[22] = '{1'b1,1'b0,13'h0500,16'h0000,1'b0,13'h0000, 1'b1,1'b0,1'b0, 1'b1,13'h0500,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000};
    vecs[23] = '{1'b1,1'b0,13'h0500,16'h0000,1'b0,13'h0000, 1'b0,1'b0,1'b0, 1'b0,13'h0000,16'h0000, 1'b1,16'h0002, 1'b0,16'h0000};

    reset = 1'b1; cpu_req = 1'b0; cpu_load = 1'b0; cpu_address = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_address = '0;
    repeat (2) @(negedge clk);

    // Post a write to 0x0010 behind a VGA fetch, then reset before it can drain.
    drive(1'b0, 1'b1, 1'b1, 13'h0010, 16'hDEAD, 1'b1, 13'h0000);
    check("post_wr_busy", 16'(cpu_busy), 16'h0);
    drive(1'b1, 1'b1, 1'b0, 13'h0010, 16'h0000, 1'b1, 13'h0000);
    check("in_reset_busy", 16'(cpu_busy), 16'h0);
    check("in_reset_we", 16'(ram_we), 16'h0);
    drive(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 13'h0000);
    watch = 1'b1;
    check("rst_busy", 16'(cpu_busy), 16'h0);
    check("rst_we", 16'(ram_we), 16'h0);
    check("rst_vvalid", 16'(vga_valid), 16'h0);
    check("rst_cpu_rdata", cpu_rdata, 16'h0);
    check("rst_vga_rdata", vga_rdata, 16'h0);

    for (int i = 0; i < 24; i++) begin
      drive(1'b0, vecs[i].req, vecs[i].load, vecs[i].addr, vecs[i].wdata,
            vecs[i].vreq, vecs[i].vaddr);
      check($sformatf("r%0d busy", i), 16'(cpu_busy), 16'(vecs[i].e_busy));
      check($sformatf("r%0d ram_we", i), 16'(ram_we), 16'(vecs[i].e_we));
      check($sformatf("r%0d vga_valid", i), 16'(vga_valid), 16'(vecs[i].e_vvalid));
      if (vecs[i].chk_ram) begin
        check($sformatf("r%0d ram_address", i), 16'(ram_address), 16'(vecs[i].e_raddr));
        if (vecs[i].e_we)
          check($sformatf("r%0d ram_wdata", i), ram_wdata, vecs[i].e_wdata);
      end
      if (vecs[i].chk_rd)
        check($sformatf("r%0d cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
      if (vecs[i].chk_vrd)
        check($sformatf("r%0d vga_rdata", i), vga_rdata, vecs[i].e_vrd);
    end

    drive(1'b0, 1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 13'h0000);
    check("discarded_wbuf_drain", 16'(bad_drain), 16'h0);
    check("mem_0x0010_untouched", mem[13'h0010], 16'hC010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
